// File: rtl/mi3_pio_uart_tx_pkg.sv
// Shared definitions for the mi3 PIO-driven UART transmitter.
// Holds the FSM state encodings, the command-word field positions and a
// helper that turns the nbytes-1 field into the number of bytes still to
// send after the first one.
package mi3_pio_uart_tx_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Command word field positions
    localparam int REQ_TOG_BIT = 31;
    localparam int NB_LSB      = 24;
    localparam int NB_MSB      = 25;
    localparam int PAYLOAD_MSB = 23;

    // Bytes remaining after the first frame; a field value of 3 is treated as 2
    // because the payload only carries three bytes.
    function automatic logic [1:0] extra_bytes(input logic [1:0] nb_field);
        logic [1:0] result;
        case (nb_field)
            2'd0:    result = 2'd0;
            2'd1:    result = 2'd1;
            2'd2:    result = 2'd2;
            default: result = 2'd2;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mi3_bit_timer.sv
// UART bit-time generator.
// Counts 0..CLKS_PER_BIT-1 while enabled and pulses tick on the last count,
// so tick fires once every CLKS_PER_BIT enabled cycles.
// Ports:
//   clk     - system clock
//   reset_n - asynchronous active-low reset
//   clear   - restart the bit period (takes priority over enable)
//   enable  - count while high
//   tick    - high for the last cycle of each bit period
module mi3_bit_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int              CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_r;

    assign tick = enable && (cnt_r == LAST);

    // Bit-period counter with wrap at the last count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear) begin
            cnt_r <= {CW{1'b0}};
        end else if (enable) begin
            if (cnt_r == LAST) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/mi3_pio_uart_tx.sv
// PIO-commanded UART transmitter (8N1, LSB first).
// Software writes a command word to a PIO; a flip of bit 31 relative to the
// last accepted value requests transmission of 1..3 payload bytes.
// Ports:
//   clk        - system clock
//   reset_n    - asynchronous active-low reset
//   in_port    - command word: [31] req toggle, [25:24] nbytes-1, [23:0] payload
//   tx         - UART serial output, idle high
//   busy       - high from acceptance until the last stop bit ends
//   ack_toggle - inverts once per completed request
module mi3_pio_uart_tx
    import mi3_pio_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] in_port,
    output logic        tx,
    output logic        busy,
    output logic        ack_toggle
);

    logic [31:0] word_r;
    logic        last_tog_r;
    logic [1:0]  state_r;
    logic [23:0] shift_r;
    logic [6:0]  frame_r;
    logic [2:0]  bit_idx_r;
    logic [1:0]  bytes_left_r;
    logic        tx_r;
    logic        busy_r;
    logic        ack_r;
    logic        pend_s;
    logic        tick_s;
    logic        unused_bits_s;

    // Bits [30:26] carry no meaning in the command word
    assign unused_bits_s = ^word_r[30:26];

    assign pend_s = (state_r == ST_IDLE) && (word_r[REQ_TOG_BIT] != last_tog_r);

    assign tx         = tx_r;
    assign busy       = busy_r;
    assign ack_toggle = ack_r;

    // Restart the timer on acceptance so the first start bit is full length
    mi3_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (pend_s),
        .enable  (state_r != ST_IDLE),
        .tick    (tick_s)
    );

    // Single register stage on the PIO word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_r <= 32'h0000_0000;
        end else begin
            word_r <= in_port;
        end
    end

    // Transmit FSM, shift register and request/acknowledge toggles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            last_tog_r   <= 1'b0;
            shift_r      <= 24'h00_0000;
            frame_r      <= 7'h00;
            bit_idx_r    <= 3'd0;
            bytes_left_r <= 2'd0;
            tx_r         <= 1'b1;
            busy_r       <= 1'b0;
            ack_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pend_s) begin
                        state_r      <= ST_START;
                        last_tog_r   <= word_r[REQ_TOG_BIT];
                        shift_r      <= word_r[PAYLOAD_MSB:0];
                        bytes_left_r <= extra_bytes(word_r[NB_MSB:NB_LSB]);
                        tx_r         <= 1'b0;
                        busy_r       <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        // bit 0 goes out now; bits 7:1 wait in frame_r
                        state_r   <= ST_DATA;
                        tx_r      <= shift_r[0];
                        frame_r   <= shift_r[7:1];
                        bit_idx_r <= 3'd0;
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                            tx_r    <= 1'b1;
                        end else begin
                            tx_r      <= frame_r[0];
                            frame_r   <= {1'b0, frame_r[6:1]};
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick_s) begin
                        if (bytes_left_r != 2'd0) begin
                            // next frame follows with no idle gap
                            state_r      <= ST_START;
                            bytes_left_r <= bytes_left_r - 2'd1;
                            shift_r      <= {8'h00, shift_r[23:8]};
                            tx_r         <= 1'b0;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            ack_r   <= ~ack_r;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mi3_pio_uart_tx.sv
// Self-checking bench for mi3_pio_uart_tx with CLKS_PER_BIT = 4.
// A mid-bit sampling UART monitor decodes frames into a queue; the expected
// frames and busy lengths come from the command-word rules directly.
module tb_mi3_pio_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] in_port;
    logic        tx;
    logic        busy;
    logic        ack_toggle;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int rst_cnt     = 0;

    logic [8:0] rx_q[$];
    logic [8:0] exp_q[$];
    int         st_q[$];
    logic       tog;

    mi3_pio_uart_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .tx         (tx),
        .busy       (busy),
        .ack_toggle (ack_toggle)
    );

    // Clock generation
    always #5 clk = ~clk;

    // Cycle counter for frame start times
    always @(posedge clk) cyc <= cyc + 1;

    // Reset event counter, lets the monitor drop frames cut by reset
    always @(negedge reset_n) rst_cnt <= rst_cnt + 1;

    // UART monitor: detect start bit, sample each bit in its middle
    initial begin : uart_mon
        logic [7:0] b;
        int         st;
        int         r0;
        logic       ab;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && tx === 1'b0) begin
                st = cyc;
                r0 = rst_cnt;
                ab = 1'b0;
                repeat (2) @(negedge clk);
                if (tx !== 1'b0) ab = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (rst_cnt != r0 || reset_n !== 1'b1) ab = 1'b1;
                if (!ab) begin
                    rx_q.push_back({tx, b});
                    st_q.push_back(st);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Number of bytes a command word asks for
    function automatic int nbytes(input logic [31:0] w);
        return (w[25:24] == 2'd3) ? 3 : int'(w[25:24]) + 1;
    endfunction

    // Expected frames: stop bit 1 over each payload byte, byte 0 first
    task automatic push_exp(input logic [31:0] w);
        for (int i = 0; i < nbytes(w); i++) exp_q.push_back({1'b1, w[8*i +: 8]});
    endtask

    // Apply a command word and check the acceptance latency
    task automatic issue(input logic [31:0] w);
        in_port = w;
        tog     = w[31];
        @(negedge clk);
        chk("pre_accept_busy", busy, 1'b0);
        @(negedge clk);
        chk("accept_busy", busy, 1'b1);
        chk("start_tx", tx, 1'b0);
    endtask

    // Count busy cycles (optionally rewriting in_port mid-frame) and check ack
    task automatic track(input int c1, input logic [31:0] w1,
                         input int c2, input logic [31:0] w2, input int exp_len);
        int   len;
        logic a0;
        logic a_exp;
        logic early;
        len   = 1;
        a0    = ack_toggle;
        a_exp = ~a0;
        early = 1'b0;
        while (busy === 1'b1 && len < 200) begin
            if (len == c1) in_port = w1;
            if (len == c2) in_port = w2;
            @(negedge clk);
            if (busy === 1'b1) begin
                len++;
                if (ack_toggle !== a0) early = 1'b1;
            end
        end
        chk("busy_len", len, exp_len);
        chk("ack_early", early, 1'b0);
        chk("ack_flip", ack_toggle, a_exp);
    endtask

    // Compare decoded frames with expected ones, then clear the queues
    task automatic cmp_rx(input string tag);
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) chk(tag, rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
        st_q.delete();
    endtask

    // Expect no activity on busy/tx for n cycles
    task automatic idle_check(input string tag, input int n);
        logic act;
        act = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) act = 1'b1;
        end
        chk(tag, act, 1'b0);
    endtask

    initial begin : stim
        logic [31:0] w;
        logic [31:0] w2;
        logic [31:0] w3;
        logic [1:0]  nb;

        // 1. reset
        reset_n = 1'b0;
        in_port = 32'h0000_0000;
        tog     = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_ack", ack_toggle, 1'b0);
        reset_n = 1'b1;
        idle_check("idle_after_reset", 100);
        chk("no_rx_after_reset", rx_q.size(), 0);

        // 2. single byte
        w = 32'h8000_00A5;
        push_exp(w);
        issue(w);
        track(-1, 32'h0, -1, 32'h0, FRAME);
        cmp_rx("single_a5");

        // 3. three bytes back to back
        w = 32'h0233_2211;
        push_exp(w);
        issue(w);
        track(-1, 32'h0, -1, 32'h0, 3 * FRAME);
        chk("frames_3", st_q.size(), 3);
        if (st_q.size() == 3) begin
            chk("gap_01", st_q[1] - st_q[0], FRAME);
            chk("gap_12", st_q[2] - st_q[1], FRAME);
        end
        cmp_rx("three_bytes");

        w = {1'b1, 5'b10101, 2'b11, 24'h33CC5A};
        push_exp(w);
        issue(w);
        track(-1, 32'h0, -1, 32'h0, 3 * FRAME);
        cmp_rx("nb_field_3");

        // randomized requests
        for (int k = 0; k < 6; k++) begin
            nb = 2'($urandom_range(0, 3));
            w  = {~tog, 5'($urandom), nb, 24'($urandom)};
            push_exp(w);
            issue(w);
            track(-1, 32'h0, -1, 32'h0, nbytes(w) * FRAME);
            cmp_rx("random");
        end

        // 4. toggle while busy: queued request starts one cycle after busy falls
        w = {~tog, 7'd0, 24'h000055};
        push_exp(w);
        issue(w);
        w2 = {~tog, 7'd0, 24'h0000C3};
        push_exp(w2);
        track(10, w2, -1, 32'h0, FRAME);
        tog = w2[31];
        @(negedge clk);
        chk("queued_accept_busy", busy, 1'b1);
        chk("queued_accept_tx", tx, 1'b0);
        track(-1, 32'h0, -1, 32'h0, FRAME);
        cmp_rx("toggle_busy");

        // two toggles mid-frame cancel out
        w = {~tog, 7'd0, 24'h000055};
        push_exp(w);
        issue(w);
        w2 = {~tog, 7'd0, 24'h0000C3};
        w3 = {tog, 7'd0, 24'h0000C3};
        track(10, w2, 20, w3, FRAME);
        idle_check("double_toggle_idle", 30);
        cmp_rx("double_toggle");

        // 6. payload change without toggle
        w = {~tog, 7'd0, 24'h00005A};
        push_exp(w);
        issue(w);
        w2 = {tog, 5'd0, 2'd2, 24'hFFFFFF};
        track(10, w2, -1, 32'h0, FRAME);
        idle_check("payload_change_idle", 30);
        cmp_rx("payload_change");

        // 5. reset mid-frame
        w = {~tog, 7'd0, 24'h0000F0};
        issue(w);
        repeat (14) @(negedge clk);
        #2;
        reset_n = 1'b0;
        in_port = 32'h0000_0000;
        #1;
        chk("midreset_tx", tx, 1'b1);
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_ack", ack_toggle, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        tog     = 1'b0;
        idle_check("idle_after_mid_reset", 100);
        chk("no_rx_after_mid_reset", rx_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
